// File: rtl/stack_pkg.sv
// Shared definitions for the parameterised LIFO stack: overflow policy
// selection and the pointer-width helper used to size sp and count.
package stack_pkg;

    typedef enum logic {
        STK_REJECT = 1'b0,
        STK_WRAP   = 1'b1
    } stack_mode_e;

    // Depth is a power of two >= 2, so this is exactly log2(depth).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH array with one synchronous write port and one
// asynchronous read port. No reset; contents are only observed when valid.
module stack_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_stack.sv
// LIFO stack with selectable overflow policy (reject or wrap over the oldest
// entry), replace-top on simultaneous push+pop, and sticky error flags.
module param_stack
    import stack_pkg::*;
#(
    parameter int          WIDTH = 12,
    parameter int          DEPTH = 8,
    parameter stack_mode_e MODE  = STK_REJECT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clr_err,
    input  logic [WIDTH-1:0]          writeData,
    output logic [WIDTH-1:0]          readData,
    output logic [ptr_width(DEPTH):0] count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int          PW      = ptr_width(DEPTH);
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    sp_q, sp_d;
    logic [PW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             memWe;
    logic [PW-1:0]    memWaddr;
    logic [PW-1:0]    spTop;
    logic [WIDTH-1:0] memRdata;
    logic             isFull, isEmpty;

    assign spTop   = sp_q - PTR_ONE;
    assign isFull  = (count_q == CNT_MAX);
    assign isEmpty = (count_q == '0);

    // Flag-setting events override a same-cycle clr_err.
    always_comb begin
        sp_d     = sp_q;
        count_d  = count_q;
        ovf_d    = ovf_q & ~clr_err;
        unf_d    = unf_q & ~clr_err;
        memWe    = 1'b0;
        memWaddr = sp_q;
        if (push && pop && !isEmpty) begin
            memWe    = 1'b1;
            memWaddr = spTop;
        end else if (push) begin
            if (!isFull) begin
                memWe   = 1'b1;
                sp_d    = sp_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end else begin
                ovf_d = 1'b1;
                if (MODE == STK_WRAP) begin
                    memWe = 1'b1;
                    sp_d  = sp_q + PTR_ONE;
                end
            end
        end else if (pop) begin
            if (!isEmpty) begin
                sp_d    = spTop;
                count_d = count_q - CNT_ONE;
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (memWe & rst),
        .waddr (memWaddr),
        .wdata (writeData),
        .raddr (spTop),
        .rdata (memRdata)
    );

    assign readData  = isEmpty ? '0 : memRdata;
    assign count     = count_q;
    assign full      = isFull;
    assign empty     = isEmpty;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
